dm_axi_master: RTL and testbench

DM_AXI_MASTER -- requirements
Module: dm_axi_master

---
 rtl/dm_axi_master.sv | 216 +++++++++++++++++++++
 tb/tb_dm_axi_master.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_axi_master.sv
// Data-memory side AXI master: converts single CPU MEM-stage requests into
// single-beat AXI reads or writes and stalls the pipeline until done.
module dm_axi_master #(
    parameter logic [3:0] MASTER_ID = 4'd1,
    parameter int         DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_DM_CS,
    input  logic              i_DM_OE,
    input  logic [3:0]        i_DM_WEB,
    input  logic [DATA_W-1:0] i_DM_addr,
    input  logic [DATA_W-1:0] i_DM_DI,
    output logic [DATA_W-1:0] o_DM_DO,
    output logic              o_mem_stall,
    output logic              o_bus_err,

    output logic [3:0]        AWID,
    output logic [DATA_W-1:0] AWADDR,
    output logic [3:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,

    output logic [DATA_W-1:0] WDATA,
    output logic [3:0]        WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,

    input  logic [3:0]        BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,

    output logic [3:0]        ARID,
    output logic [DATA_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,

    input  logic [3:0]        RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR,
        S_B,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        strb_q;
    logic              aw_done;
    logic              w_done;

    logic req_wr;
    logic req_rd;
    logic aw_fire;
    logic w_fire;
    logic r_fire;
    logic b_fire;
    logic issue;

    // Only one transaction is ever outstanding, so IDs and RLAST carry no information.
    logic unused_ok;
    assign unused_ok = &{1'b0, RID, BID, RLAST};

    // A write wins over a read when both decode.
    assign req_wr = i_DM_CS && (i_DM_WEB != 4'hF);
    assign req_rd = i_DM_CS && i_DM_OE && (i_DM_WEB == 4'hF);
    assign issue  = (state == S_IDLE) && (req_wr || req_rd);

    assign aw_fire = (state == S_WR) && !aw_done && AWREADY;
    assign w_fire  = (state == S_WR) && !w_done && WREADY;
    assign r_fire  = (state == S_R) && RVALID;
    assign b_fire  = (state == S_B) && BVALID;

    // Fixed single-beat, word-sized INCR attributes; payload comes from the captured request.
    assign AWID    = MASTER_ID;
    assign ARID    = MASTER_ID;
    assign AWLEN   = 4'd0;
    assign ARLEN   = 4'd0;
    assign AWSIZE  = 3'b010;
    assign ARSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign ARBURST = 2'b01;
    assign WLAST   = 1'b1;
    assign AWADDR  = addr_q;
    assign ARADDR  = addr_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = strb_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and channel handshake outputs.
    always_comb begin
        next_state  = state;
        ARVALID     = 1'b0;
        RREADY      = 1'b0;
        AWVALID     = 1'b0;
        WVALID      = 1'b0;
        BREADY      = 1'b0;
        o_mem_stall = 1'b0;
        case (state)
            S_IDLE: begin
                o_mem_stall = req_wr || req_rd;
                if (req_wr) begin
                    next_state = S_WR;
                end else if (req_rd) begin
                    next_state = S_AR;
                end
            end
            S_AR: begin
                ARVALID     = 1'b1;
                o_mem_stall = 1'b1;
                if (ARREADY) begin
                    next_state = S_R;
                end
            end
            S_R: begin
                RREADY      = 1'b1;
                o_mem_stall = 1'b1;
                if (RVALID) begin
                    next_state = S_DONE;
                end
            end
            S_WR: begin
                AWVALID     = !aw_done;
                WVALID      = !w_done;
                o_mem_stall = 1'b1;
                if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                    next_state = S_B;
                end
            end
            S_B: begin
                BREADY      = 1'b1;
                o_mem_stall = 1'b1;
                if (BVALID) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Request capture and per-channel completion flags for the write phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (issue) begin
                addr_q  <= i_DM_addr;
                wdata_q <= i_DM_DI;
                strb_q  <= ~i_DM_WEB;
            end
            if (state == S_WR && next_state == S_WR) begin
                if (aw_fire) begin
                    aw_done <= 1'b1;
                end
                if (w_fire) begin
                    w_done <= 1'b1;
                end
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    // Load data and sticky bus-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_DM_DO   <= '0;
            o_bus_err <= 1'b0;
        end else begin
            if (r_fire) begin
                o_DM_DO <= RDATA;
            end
            if ((r_fire && RRESP != 2'b00) || (b_fire && BRESP != 2'b00)) begin
                o_bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dm_axi_master.sv
// Scoreboard bench for dm_axi_master: a CPU-side driver, an AXI slave with
// its own memory, and a monitor that checks bus beats and completions.
module tb_dm_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_DM_CS, i_DM_OE;
    logic [3:0]  i_DM_WEB;
    logic [31:0] i_DM_addr, i_DM_DI, o_DM_DO;
    logic        o_mem_stall, o_bus_err;
    logic [3:0]  AWID, AWLEN, ARID, ARLEN, BID, RID, WSTRB;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 clk = ~clk;

    dm_axi_master #(.MASTER_ID(4'd1), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_DM_CS(i_DM_CS), .i_DM_OE(i_DM_OE), .i_DM_WEB(i_DM_WEB),
        .i_DM_addr(i_DM_addr), .i_DM_DI(i_DM_DI), .o_DM_DO(o_DM_DO),
        .o_mem_stall(o_mem_stall), .o_bus_err(o_bus_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } bus_t;

    typedef struct {
        logic [31:0] dout;
        bit          err;
    } res_t;

    bus_t exp_q[$];
    res_t res_q[$];

    // Reference model state (CPU view) and slave memory (bus view).
    logic [31:0] mem_ref [0:15];
    logic [31:0] mem_slv [0:15];
    logic [31:0] model_do;
    bit          model_err;

    // Slave behaviour knobs, written by the driver.
    bit cur_err  = 1'b0;
    bit rand_dly = 1'b0;
    int ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event, expected none", name);
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'h1357_9BDF + (32'(i) * 32'h0F1E_2D3C);
    endfunction

    // AXI slave: ready delays per channel, response after AR or after both AW and W.
    initial begin
        int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
        bit r_pend = 0, b_pend = 0, s_aw = 0, s_w = 0;
        logic [31:0] r_word = '0, s_addr = '0, s_data = '0;
        logic [3:0]  s_strb = '0;
        logic [1:0]  r_resp = '0, b_resp = '0;
        ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
        RDATA = '0; RRESP = '0; RID = '0; RLAST = 0; BID = '0; BRESP = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
                r_pend = 0; b_pend = 0; s_aw = 0; s_w = 0;
            end else begin
                if (ARVALID && ARREADY) begin
                    r_pend = 1; r_cnt = 0;
                    r_word = mem_slv[ARADDR[5:2]];
                    r_resp = cur_err ? 2'b10 : 2'b00;
                    ar_cnt = 0;
                    if (rand_dly) ar_dly = $urandom_range(0, 3);
                end else if (ARVALID) ar_cnt++;
                if (AWVALID && AWREADY) begin
                    s_aw = 1; s_addr = AWADDR; aw_cnt = 0;
                    if (rand_dly) aw_dly = $urandom_range(0, 3);
                end else if (AWVALID) aw_cnt++;
                if (WVALID && WREADY) begin
                    s_w = 1; s_data = WDATA; s_strb = WSTRB; w_cnt = 0;
                    if (rand_dly) w_dly = $urandom_range(0, 3);
                end else if (WVALID) w_cnt++;
                if (RVALID && RREADY) begin
                    r_pend = 0;
                    if (rand_dly) r_dly = $urandom_range(0, 3);
                end else if (r_pend && !RVALID) r_cnt++;
                if (BVALID && BREADY) begin
                    b_pend = 0;
                    if (rand_dly) b_dly = $urandom_range(0, 3);
                end else if (b_pend && !BVALID) b_cnt++;
                if (s_aw && s_w) begin
                    for (int b = 0; b < 4; b++)
                        if (s_strb[b]) mem_slv[s_addr[5:2]][8*b +: 8] = s_data[8*b +: 8];
                    b_pend = 1; b_cnt = 0;
                    b_resp = cur_err ? 2'b10 : 2'b00;
                    s_aw = 0; s_w = 0;
                end
            end
            @(posedge clk);
            #2;
            ARREADY = !rst && (ar_cnt >= ar_dly);
            AWREADY = !rst && (aw_cnt >= aw_dly);
            WREADY  = !rst && (w_cnt >= w_dly);
            RVALID  = !rst && r_pend && (r_cnt >= r_dly);
            BVALID  = !rst && b_pend && (b_cnt >= b_dly);
            RDATA   = RVALID ? r_word : $urandom;
            RRESP   = RVALID ? r_resp : 2'($urandom_range(0, 3));
            BRESP   = BVALID ? b_resp : 2'($urandom_range(0, 3));
            RID     = 4'($urandom_range(0, 15));
            BID     = 4'($urandom_range(0, 15));
            RLAST   = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: protocol stability, bus beats against the expected queue, completions.
    initial begin
        bit got_aw = 0, got_w = 0, prev_stall = 0;
        bit ar_hold = 0, aw_hold = 0, w_hold = 0;
        logic [31:0] aw_addr = '0, w_data = '0, ar_prev = '0, aw_prev = '0, wd_prev = '0;
        logic [3:0]  w_strb = '0, ws_prev = '0;
        bus_t e;
        res_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                got_aw = 0; got_w = 0; prev_stall = 0;
                ar_hold = 0; aw_hold = 0; w_hold = 0;
            end else begin
                if (ar_hold) begin
                    chk("arvalid_held", ARVALID, 1);
                    chk("araddr_stable", ARADDR, ar_prev);
                end
                if (aw_hold) begin
                    chk("awvalid_held", AWVALID, 1);
                    chk("awaddr_stable", AWADDR, aw_prev);
                end
                if (w_hold) begin
                    chk("wvalid_held", WVALID, 1);
                    chk("wdata_stable", WDATA, wd_prev);
                    chk("wstrb_stable", WSTRB, ws_prev);
                end
                if (got_w) chk("wvalid_dropped", WVALID, 0);
                if (got_aw) chk("awvalid_dropped", AWVALID, 0);

                if (ARVALID && ARREADY) begin
                    if (exp_q.size() == 0) fail_event("unexpected_ar");
                    else begin
                        e = exp_q.pop_front();
                        chk("ar_kind_is_read", e.wr, 0);
                        chk("araddr", ARADDR, e.addr);
                        chk("arid", ARID, 4'd1);
                        chk("arlen", ARLEN, 4'd0);
                        chk("arsize", ARSIZE, 3'b010);
                        chk("arburst", ARBURST, 2'b01);
                    end
                end
                if (AWVALID && AWREADY) begin
                    if (got_aw) fail_event("duplicate_aw");
                    got_aw = 1; aw_addr = AWADDR;
                    chk("awid", AWID, 4'd1);
                    chk("awlen", AWLEN, 4'd0);
                    chk("awsize", AWSIZE, 3'b010);
                    chk("awburst", AWBURST, 2'b01);
                end
                if (WVALID && WREADY) begin
                    if (got_w) fail_event("duplicate_w");
                    got_w = 1; w_data = WDATA; w_strb = WSTRB;
                    chk("wlast", WLAST, 1);
                end
                if (got_aw && got_w) begin
                    if (exp_q.size() == 0) fail_event("unexpected_write");
                    else begin
                        e = exp_q.pop_front();
                        chk("w_kind_is_write", e.wr, 1);
                        chk("awaddr", aw_addr, e.addr);
                        chk("wdata", w_data, e.data);
                        chk("wstrb", w_strb, e.strb);
                    end
                    got_aw = 0; got_w = 0;
                end

                if (prev_stall && !o_mem_stall) begin
                    if (res_q.size() == 0) fail_event("unexpected_completion");
                    else begin
                        r = res_q.pop_front();
                        chk("dm_do", o_DM_DO, r.dout);
                        chk("bus_err", o_bus_err, r.err);
                    end
                end
                prev_stall = o_mem_stall;
                ar_hold = ARVALID && !ARREADY; ar_prev = ARADDR;
                aw_hold = AWVALID && !AWREADY; aw_prev = AWADDR;
                w_hold  = WVALID && !WREADY;   wd_prev = WDATA; ws_prev = WSTRB;
            end
        end
    end

    task automatic drive_idle();
        i_DM_CS = 0; i_DM_OE = 0; i_DM_WEB = 4'hF; i_DM_addr = '0; i_DM_DI = '0;
    endtask

    // One CPU request: update the model, queue expectations, hold until the stall drops.
    task automatic run_txn(input bit wr, input int idx, input logic [31:0] di,
                           input logic [3:0] web, input bit oe, input bit err, input int exp_cyc);
        bus_t e;
        res_t r;
        int cyc;
        logic [31:0] addr;
        addr = 32'h0001_0000 | (32'(idx) << 2);
        e.wr = wr; e.addr = addr; e.data = di; e.strb = ~web;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (!web[b]) mem_ref[idx][8*b +: 8] = di[8*b +: 8];
        end else begin
            model_do = mem_ref[idx];
        end
        model_err = model_err | err;
        r.dout = model_do; r.err = model_err;
        exp_q.push_back(e);
        res_q.push_back(r);
        cur_err = err;
        i_DM_CS = 1; i_DM_OE = oe; i_DM_WEB = wr ? web : 4'hF;
        i_DM_addr = addr; i_DM_DI = di;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!o_mem_stall) break;
            cyc++;
            if (cyc > 200) begin
                fail_event("stall_timeout");
                finish_sim();
            end
        end
        chk("stall_min_cycles", (cyc >= 3), 1);
        if (exp_cyc >= 0) chk("stall_cycles", cyc, exp_cyc);
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic no_request(input bit cs, input bit oe, input logic [3:0] web);
        i_DM_CS = cs; i_DM_OE = oe; i_DM_WEB = web; i_DM_addr = 32'h0001_0010;
        @(negedge clk);
        chk("no_req_stall", o_mem_stall, 0);
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    initial begin
        bus_t e;
        int wait_cyc;
        int kind, idx, gap;
        for (int i = 0; i < 16; i++) begin
            mem_ref[i] = init_word(i);
            mem_slv[i] = init_word(i);
        end
        model_do = '0;
        model_err = 0;
        drive_idle();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_do", o_DM_DO, 0);
        chk("rst_err", o_bus_err, 0);
        chk("rst_stall", o_mem_stall, 0);
        chk("rst_valids", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 0);
        #2 rst = 0;
        @(posedge clk);
        #1;

        // Minimum-latency read: IDLE, AR, R.
        run_txn(0, 3, '0, 4'hF, 1, 0, 3);
        // Read with two-cycle ARREADY delay.
        mem_ref[1] = 32'hDEAD_BEEF;
        mem_slv[1] = 32'hDEAD_BEEF;
        ar_dly = 2;
        run_txn(0, 1, '0, 4'hF, 1, 0, 5);
        ar_dly = 0;
        // Byte write to lane 0.
        run_txn(1, 2, 32'h0000_00AB, 4'b1110, 0, 0, 3);
        run_txn(0, 2, '0, 4'hF, 1, 0, 3);
        // W accepted three cycles before AW.
        aw_dly = 3;
        run_txn(1, 5, 32'hCAFE_F00D, 4'b0000, 0, 0, 6);
        aw_dly = 0;
        // AW accepted before W.
        w_dly = 2;
        run_txn(1, 4, 32'h1234_5678, 4'b0101, 0, 0, 5);
        w_dly = 0;
        // Error response on a write, then an OKAY read keeps the flag.
        run_txn(1, 6, 32'h5555_AAAA, 4'b1100, 0, 1, -1);
        run_txn(0, 6, '0, 4'hF, 1, 0, -1);
        // Back-to-back read, write, read of the same word.
        run_txn(0, 7, '0, 4'hF, 1, 0, 3);
        run_txn(1, 7, 32'hA1B2_C3D4, 4'b0011, 0, 0, 3);
        run_txn(0, 7, '0, 4'hF, 1, 0, 3);
        // Non-requests and write-wins decode.
        no_request(1, 0, 4'hF);
        no_request(0, 1, 4'h0);
        run_txn(1, 8, 32'h0F0F_0F0F, 4'b0110, 1, 0, 3);

        // Reset while waiting in R with RVALID low.
        r_dly = 10;
        e.wr = 0; e.addr = 32'h0001_0024; e.data = '0; e.strb = '0;
        exp_q.push_back(e);
        cur_err = 0;
        i_DM_CS = 1; i_DM_OE = 1; i_DM_WEB = 4'hF; i_DM_addr = 32'h0001_0024;
        wait_cyc = 0;
        forever begin
            @(negedge clk);
            if (RREADY) break;
            wait_cyc++;
            if (wait_cyc > 50) begin
                fail_event("rready_timeout");
                finish_sim();
            end
        end
        #2;
        rst = 1;
        drive_idle();
        #1;
        chk("rst_mid_valids", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 0);
        chk("rst_mid_do", o_DM_DO, 0);
        chk("rst_mid_err", o_bus_err, 0);
        chk("rst_mid_stall", o_mem_stall, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 0;
        r_dly = 0;
        model_do = '0;
        model_err = 0;
        @(posedge clk);
        #1;
        run_txn(0, 9, '0, 4'hF, 1, 0, 3);

        // Randomized traffic with random slave delays and occasional error responses.
        rand_dly = 1;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            idx  = $urandom_range(0, 15);
            if (kind < 2)
                run_txn(0, idx, $urandom, 4'hF, 1, ($urandom_range(0, 9) == 0), -1);
            else
                run_txn(1, idx, $urandom, 4'($urandom_range(0, 14)), (kind == 3),
                        ($urandom_range(0, 9) == 0), -1);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                i_DM_CS = 1'($urandom_range(0, 1));
                i_DM_OE = 0;
                i_DM_WEB = 4'hF;
                @(posedge clk);
                #1;
            end
            drive_idle();
        end

        repeat (5) @(posedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("res_queue_drained", res_q.size(), 0);
        finish_sim();
    end

endmodule
